fsk_mod_tx: RTL and testbench
=============================

Name: fsk_mod_tx

Overview:
- 2FSK modulator: the transmit-side counterpart of the team's 2FSK demodulation chain.
- Accepts bytes over a valid/ready handshake and serialises them MSB first, one bit per BAUD_DIV clocks.
- Each bit drives a phase-continuous DDS with frequency FTW0 (bit 0) or FTW1 (bit 1).
- Output is an 11-bit unsigned offset-binary sine sample stream that feeds the DAC and the demod loopback bench.

Parameters:
- PHASE_W, 24, phase accumulator width in bits.
- BAUD_DIV, 16, clocks per symbol; legal range ≥2.
- FTW0, 24'h100000, tuning word for bit 0 (fclk/16 at defaults).
- FTW1, 24'h200000, tuning word for bit 1 (fclk/8 at defaults).

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, 8, byte to transmit.
- data_valid, input, 1, data_in is valid.
- data_ready, output, 1, block can accept a byte this cycle.
- fsk_out, output, 11, modulated sample, unsigned, mid-scale 1024.
- tx_bit, output, 1, bit currently being modulated.
- bit_strobe, output, 1, one-cycle pulse on the first cycle of each bit.
- busy, output, 1, high while in SEND.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, phase_acc=0, shreg=0, bit_cnt=0, baud_cnt=0.
  - Output reset values: fsk_out=11'd1024, tx_bit=0, bit_strobe=0, busy=0, data_ready=0 while rst_n low.
  - After reset deasserts, data_ready=1 in IDLE.
- States:
  - IDLE: data_ready=1; phase_acc held at 0; fsk_out driven to 1024 each cycle.
  - SEND: modulation active.
- Accept rule: a transfer occurs on a clock edge where data_valid && data_ready. data_in is ignored at all other times.
- IDLE→SEND on accept, at edge t+1:
  - shreg<=data_in, bit_cnt<=0, baud_cnt<=0, phase_acc<=0.
  - bit_strobe=1 and busy=1 during cycle t+1.
- Per-cycle operation in SEND:
  - Current bit: cur=shreg[7], and tx_bit=cur.
  - phase_acc <= phase_acc + (cur ? FTW1 : FTW0), modulo 2^PHASE_W (wrap-around, no saturation).
  - fsk_out <= SINE[phase_acc[PHASE_W-1 -: 8]]. fsk_out therefore lags phase_acc by one cycle, and the first sample after accept appears at edge t+2.
- Symbol timing:
  - baud_cnt counts 0..BAUD_DIV-1.
  - When it reaches BAUD_DIV-1: baud_cnt<=0, shreg<=shreg<<1, bit_cnt++, bit_strobe=1 in the following cycle.
  - Byte duration is exactly 8*BAUD_DIV cycles.
- Phase continuity: phase_acc is never reset at a bit boundary or between back-to-back bytes, only on entry from IDLE.
- Last cycle of a byte (bit_cnt==7 && baud_cnt==BAUD_DIV-1):
  - data_ready=1 combinationally.
  - If a byte is accepted, the next cycle reloads shreg, bit_cnt=0, stays in SEND with no gap cycle, and pulses bit_strobe.
  - Otherwise go to IDLE: phase_acc<=0, and fsk_out=1024 from the following edge.
- data_ready=0 in all other SEND cycles.
- SINE LUT: 256 entries, SINE[k] = 1024 + round(1023*sin(2πk/256)).
  - Range 1..2047; SINE[0]=1024, SINE[64]=2047, SINE[128]=1024, SINE[192]=1.
  - Implemented as a synthesisable ROM (case or initialised array); a quarter-wave table with symmetry is permitted if bit-identical.
- Reset mid-byte: asynchronous clear to reset values. The partial byte is discarded and never resumed.
- data_valid held high in IDLE with no handshake pending: accepted at the first edge, and exactly one byte per handshake.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with data_valid=1 → fsk_out=1024, data_ready=0, busy=0; after release, data_ready=1 and no byte is accepted before the first rising edge with rst_n=1.
- Single byte 8'h00 at defaults → after accept, fsk_out = 1024, 1415, 1747, 1969, 2047, 1969, … (period 16 clocks); busy high for exactly 128 cycles; bit_strobe pulses 8 times, 16 cycles apart; return to 1024 afterwards.
- Single byte 8'hFF → fsk_out period 8 clocks: 1024, 1747, 2047, 1747, 1024, 301, 1, 301, …; tx_bit=1 throughout.
- Byte 8'hA5 → tx_bit sequence 1,0,1,0,0,1,0,1, each bit 16 cycles; at every bit boundary phase_acc continues without a reset (check against a reference model, zero sample mismatches).
- Back-to-back 8'h0F then 8'hF0 with data_valid held → second accept occurs in the last cycle of the first byte; busy stays high for 256 consecutive cycles; no 1024 gap sample at the boundary.
- Assert rst_n=0 during bit 3 of 8'h55 → outputs immediately take reset values; a subsequent byte 8'h00 transmits identically to the single-byte scenario.

Source files
------------

// File: rtl/fsk_mod_tx.sv
// 2FSK modulator: bytes in over valid/ready, shifted out MSB first, each bit steering
// a phase-continuous DDS whose sine samples leave as 11-bit offset binary.
module fsk_mod_tx #(
  parameter int                 PHASE_W  = 24,
  parameter int                 BAUD_DIV = 16,
  parameter logic [PHASE_W-1:0] FTW0     = 24'h100000,
  parameter logic [PHASE_W-1:0] FTW1     = 24'h200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [10:0] fsk_out,
  output logic        tx_bit,
  output logic        bit_strobe,
  output logic        busy
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase_acc, phase_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [BW-1:0]      baud_cnt, baud_cnt_nxt;
  logic [10:0]        fsk_nxt;
  logic               byte_end, accept;

  // Quarter-wave ROM of round(1023*sin(2*pi*k/256)), k = 0..64, unfolded by symmetry.
  function automatic logic [10:0] sine_lut(input logic [7:0] k);
    logic [6:0] idx;
    logic [9:0] q;
    idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    q   = 10'd0;
    case (idx)
      7'd0:  q = 10'd0;    7'd1:  q = 10'd25;   7'd2:  q = 10'd50;   7'd3:  q = 10'd75;
      7'd4:  q = 10'd100;  7'd5:  q = 10'd125;  7'd6:  q = 10'd150;  7'd7:  q = 10'd175;
      7'd8:  q = 10'd200;  7'd9:  q = 10'd224;  7'd10: q = 10'd249;  7'd11: q = 10'd273;
      7'd12: q = 10'd297;  7'd13: q = 10'd321;  7'd14: q = 10'd345;  7'd15: q = 10'd368;
      7'd16: q = 10'd391;  7'd17: q = 10'd415;  7'd18: q = 10'd437;  7'd19: q = 10'd460;
      7'd20: q = 10'd482;  7'd21: q = 10'd504;  7'd22: q = 10'd526;  7'd23: q = 10'd547;
      7'd24: q = 10'd568;  7'd25: q = 10'd589;  7'd26: q = 10'd609;  7'd27: q = 10'd629;
      7'd28: q = 10'd649;  7'd29: q = 10'd668;  7'd30: q = 10'd687;  7'd31: q = 10'd705;
      7'd32: q = 10'd723;  7'd33: q = 10'd741;  7'd34: q = 10'd758;  7'd35: q = 10'd775;
      7'd36: q = 10'd791;  7'd37: q = 10'd806;  7'd38: q = 10'd822;  7'd39: q = 10'd836;
      7'd40: q = 10'd851;  7'd41: q = 10'd864;  7'd42: q = 10'd877;  7'd43: q = 10'd890;
      7'd44: q = 10'd902;  7'd45: q = 10'd914;  7'd46: q = 10'd925;  7'd47: q = 10'd935;
      7'd48: q = 10'd945;  7'd49: q = 10'd954;  7'd50: q = 10'd963;  7'd51: q = 10'd971;
      7'd52: q = 10'd979;  7'd53: q = 10'd986;  7'd54: q = 10'd992;  7'd55: q = 10'd998;
      7'd56: q = 10'd1003; 7'd57: q = 10'd1008; 7'd58: q = 10'd1012; 7'd59: q = 10'd1015;
      7'd60: q = 10'd1018; 7'd61: q = 10'd1020; 7'd62: q = 10'd1022; 7'd63: q = 10'd1023;
      7'd64: q = 10'd1023;
      default: q = 10'd0;
    endcase
    return k[7] ? (11'd1024 - {1'b0, q}) : (11'd1024 + {1'b0, q});
  endfunction

  always_comb begin
    byte_end   = (state == SEND) && (bit_cnt == 3'd7) && (baud_cnt == BAUD_LAST);
    // Ready is held low while reset is asserted even though state already reads IDLE.
    data_ready = rst_n && ((state == IDLE) || byte_end);
    accept     = data_valid && data_ready;
    busy       = (state == SEND);
    bit_strobe = busy && (baud_cnt == '0);
    tx_bit     = busy && shreg[7];
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase_acc;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    baud_cnt_nxt = baud_cnt;
    fsk_nxt      = 11'd1024;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        if (accept) begin
          state_nxt    = SEND;
          shreg_nxt    = data_in;
          bit_cnt_nxt  = 3'd0;
          baud_cnt_nxt = '0;
        end
      end
      SEND: begin
        phase_nxt = phase_acc + (shreg[7] ? FTW1 : FTW0);
        fsk_nxt   = sine_lut(phase_acc[PHASE_W-1 -: 8]);
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          shreg_nxt    = shreg << 1;
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (byte_end) begin
            // A byte accepted here continues seamlessly; the phase carries over.
            if (accept) begin
              shreg_nxt   = data_in;
              bit_cnt_nxt = 3'd0;
            end else begin
              state_nxt = IDLE;
              phase_nxt = '0;
            end
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_acc <= '0;
      shreg     <= 8'd0;
      bit_cnt   <= 3'd0;
      baud_cnt  <= '0;
      fsk_out   <= 11'd1024;
    end else begin
      state     <= state_nxt;
      phase_acc <= phase_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      baud_cnt  <= baud_cnt_nxt;
      fsk_out   <= fsk_nxt;
    end
  end

endmodule

// File: tb/tb_fsk_mod_tx.sv
// Bench for fsk_mod_tx: directed byte scenarios plus random traffic, all outputs
// compared every cycle against a sample-level model built from real-valued sine math.
module tb_fsk_mod_tx;

  localparam int          BD       = 16;
  localparam int          BYTE_CYC = 8 * BD;
  localparam logic [23:0] FTW0_M   = 24'h100000;
  localparam logic [23:0] FTW1_M   = 24'h200000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [10:0] fsk_out;
  logic        tx_bit;
  logic        bit_strobe;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int fsk_log[600];
  int tx_log[600];
  int lit00[9] = '{1024, 1415, 1747, 1969, 2047, 1969, 1747, 1415, 1024};
  int litff[9] = '{1024, 1747, 2047, 1747, 1024, 301, 1, 301, 1024};
  int lita5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  fsk_mod_tx #(.PHASE_W(24), .BAUD_DIV(BD), .FTW0(FTW0_M), .FTW1(FTW1_M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fsk_out    (fsk_out),
    .tx_bit     (tx_bit),
    .bit_strobe (bit_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sine_ref(input int k);
    real s;
    s = 1023.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
    if (s >= 0.0) return 1024 + $rtoi(s + 0.5);
    else          return 1024 - $rtoi(-s + 0.5);
  endfunction

  // Model: a transmission is a byte plus a cycle index n in 0..127 within it.
  logic        m_send;
  logic [7:0]  m_byte;
  int          m_n;
  logic [23:0] m_phase;
  int          m_fsk;

  function automatic logic m_ready_f();
    return rst_n && (!m_send || m_n == BYTE_CYC - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_send  <= 1'b0;
      m_byte  <= 8'd0;
      m_n     <= 0;
      m_phase <= 24'd0;
      m_fsk   <= 1024;
    end else begin
      logic acc;
      logic cur;
      acc = data_valid && m_ready_f();
      if (m_send) begin
        cur   = m_byte[7 - m_n / BD];
        m_fsk <= sine_ref(int'(m_phase[23:16]));
        if (m_n == BYTE_CYC - 1 && !acc) begin
          m_send  <= 1'b0;
          m_phase <= 24'd0;
        end else begin
          m_phase <= m_phase + (cur ? FTW1_M : FTW0_M);
        end
        if (m_n == BYTE_CYC - 1) begin
          if (acc) begin
            m_byte <= data_in;
            m_n    <= 0;
          end
        end else begin
          m_n <= m_n + 1;
        end
      end else begin
        m_fsk   <= 1024;
        m_phase <= 24'd0;
        if (acc) begin
          m_send <= 1'b1;
          m_byte <= data_in;
          m_n    <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("data_ready", data_ready, m_ready_f());
    chk("busy", busy, m_send);
    chk("bit_strobe", bit_strobe, m_send && (m_n % BD == 0));
    chk("tx_bit", tx_bit, m_send ? m_byte[7 - m_n / BD] : 1'b0);
    chk("fsk_out", fsk_out, m_fsk);
  end

  // Present a byte and complete one handshake; returns one cycle into the transfer.
  task automatic send(input logic [7:0] b, input bit keep, input logic [7:0] nxt);
    bit ok;
    ok         = 1'b0;
    data_in    = b;
    data_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("handshake_wait", ok, 1'b1);
    @(posedge clk);
    #1;
    if (keep) data_in = nxt;
    else      data_valid = 1'b0;
  endtask

  task automatic measure(output int run, output int strobes, output int misal, output int acc_i);
    run = 0; strobes = 0; misal = 0; acc_i = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) break;
      run++;
      fsk_log[i] = fsk_out;
      tx_log[i]  = tx_bit;
      if (bit_strobe) begin
        strobes++;
        if (i % BD != 0) misal++;
      end
      if (data_valid && data_ready) begin
        acc_i = i;
        @(posedge clk);
        #1 data_valid = 1'b0;
      end
    end
    if (run >= 600) chk("busy_timeout", run, 0);
  endtask

  initial begin
    int run, strobes, misal, acc_i, ones;
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int run, strobes, misal, acc_i, ones;
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_fsk", fsk_out, 11'd1024);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", data_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // Byte 0x00, valid held since reset: accepted at the first edge.
    send(8'h00, 1'b0, 8'h00);
    measure(run, strobes, misal, acc_i);
    chk("b00_run", run, BYTE_CYC);
    chk("b00_strobes", strobes, 8);
    chk("b00_strobe_align", misal, 0);
    for (int k = 0; k < 9; k++) chk("b00_fsk", fsk_log[k + 1], lit00[k]);
    @(negedge clk);
    chk("b00_idle_fsk", fsk_out, 11'd1024);

    send(8'hFF, 1'b0, 8'h00);
    measure(run, strobes, misal, acc_i);
    ones = 0;
    for (int k = 0; k < run; k++) ones += tx_log[k];
    chk("bff_run", run, BYTE_CYC);
    chk("bff_tx_ones", ones, BYTE_CYC);
    for (int k = 0; k < 9; k++) chk("bff_fsk", fsk_log[k + 1], litff[k]);

    repeat (3) @(posedge clk);
    send(8'hA5, 1'b0, 8'h00);
    measure(run, strobes, misal, acc_i);
    chk("ba5_run", run, BYTE_CYC);
    for (int j = 0; j < 8; j++) chk("ba5_tx_bit", tx_log[16 * j + 8], lita5[j]);

    // Back-to-back: 0x0F then 0xF0 with valid held across the boundary.
    send(8'h0F, 1'b1, 8'hF0);
    measure(run, strobes, misal, acc_i);
    chk("b2b_second_accept", acc_i, BYTE_CYC - 1);
    chk("b2b_run", run, 2 * BYTE_CYC);
    chk("b2b_strobes", strobes, 16);
    chk("b2b_strobe_align", misal, 0);

    // Reset during bit 3 of 0x55, then a clean 0x00.
    send(8'h55, 1'b0, 8'h00);
    repeat (53) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_fsk", fsk_out, 11'd1024);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", data_ready, 1'b0);
    chk("midrst_tx_bit", tx_bit, 1'b0);
    chk("midrst_strobe", bit_strobe, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h00, 1'b0, 8'h00);
    measure(run, strobes, misal, acc_i);
    chk("rerun_run", run, BYTE_CYC);
    chk("rerun_strobes", strobes, 8);
    for (int k = 0; k < 9; k++) chk("rerun_fsk", fsk_log[k + 1], lit00[k]);

    // Random traffic: the per-cycle model comparison does the checking.
    repeat (3000) begin
      @(posedge clk);
      #1;
      data_valid = ($urandom_range(0, 3) == 0);
      data_in    = 8'($urandom);
    end
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (2 * BYTE_CYC + 4) @(posedge clk);
    @(negedge clk);
    chk("final_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
